ising_energy_engine: RTL and testbench

- Streaming successor of MatMul. Computes the Ising energy E = sigma^T J sigma, with each sigma bit mapped 1→+1 and 0→-1.
- J arrives as column chunks over a valid/ready stream that may stall; J elements may be configured unsigned or two's-complement signed.
- Returns the signed energy and an "improved" flag (E < energy_previous) to the annealing controller over an output valid/ready handshake.

---
 rtl/ising_energy_engine.sv | 170 +++++++++++++++++
 tb/tb_ising_energy_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ising_energy_engine.sv
// Streaming Ising energy engine: E = sigma^T J sigma with spins mapped 1->+1, 0->-1.
// J arrives column-chunked over a stallable valid/ready stream. Each beat is
// reduced to per-column dot products, then to a signed contribution that is
// accumulated. The result goes out over a valid/ready handshake.

// Signed dot product of one J column against the latched spin vector.
module ising_col_dot #(
    parameter int N         = 256,
    parameter int W         = 4,
    parameter int J_SIGNED  = 0,
    parameter int DOT_WIDTH = W + $clog2(N) + 1
) (
    input  logic [N-1:0]         sigma,
    input  logic [N*W-1:0]       col,
    output logic [DOT_WIDTH-1:0] dot
);
    function automatic logic [DOT_WIDTH-1:0] ext_elem(input logic [W-1:0] e);
        logic sbit;
        sbit = (J_SIGNED != 0) & e[W-1];
        return {{(DOT_WIDTH-W){sbit}}, e};
    endfunction

    // Spin-weighted column sum; two's-complement wrap cannot occur at DOT_WIDTH.
    always_comb begin
        dot = '0;
        for (int r = 0; r < N; r++) begin
            if (sigma[r]) dot = dot + ext_elem(col[r*W +: W]);
            else          dot = dot - ext_elem(col[r*W +: W]);
        end
    end
endmodule

module ising_energy_engine #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int J_SIGNED        = 0,
    parameter int COLS_PER_BEAT   = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic                                             abort,
    input  logic [VECTOR_SIZE-1:0]                           sigma,
    input  logic [J_ELEMENT_WIDTH+2*$clog2(VECTOR_SIZE):0]   energy_previous,
    input  logic                                             j_valid,
    output logic                                             j_ready,
    input  logic [VECTOR_SIZE*COLS_PER_BEAT*J_ELEMENT_WIDTH-1:0] j_chunk,
    output logic                                             busy,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [J_ELEMENT_WIDTH+2*$clog2(VECTOR_SIZE):0]   energy,
    output logic                                             improved
);
    localparam int NUM_BEATS    = VECTOR_SIZE / COLS_PER_BEAT;
    localparam int DOT_WIDTH    = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE) + 1;
    localparam int ENERGY_WIDTH = J_ELEMENT_WIDTH + 2*$clog2(VECTOR_SIZE) + 1;
    localparam int BEAT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int COL_BITS     = VECTOR_SIZE * J_ELEMENT_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

    state_t                                      state_q, state_d;
    logic [VECTOR_SIZE-1:0]                      sigma_q;
    logic [ENERGY_WIDTH-1:0]                     eprev_q;
    logic [BEAT_W-1:0]                           beat_q;
    logic [COLS_PER_BEAT-1:0][DOT_WIDTH-1:0]     dot_c, dot_q;
    logic [COLS_PER_BEAT-1:0]                    sgn_q;
    logic [ENERGY_WIDTH-1:0]                     contrib_c, contrib_q, acc_q;
    logic [ENERGY_WIDTH-1:0]                     energy_q;
    logic                                        improved_q;
    // [0]: dot_q holds a beat, [1]: contrib_q holds a beat
    logic [1:0]                                  vld_pipe;

    logic accept, last_beat, abort_hit, start_hit;

    assign accept    = (state_q == RUN) && j_valid && !abort;
    assign last_beat = (beat_q == BEAT_W'(NUM_BEATS-1));
    assign abort_hit = abort && ((state_q == RUN) || (state_q == DRAIN));
    assign start_hit = start && (state_q == IDLE);

    assign j_ready   = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == RESULT);
    assign energy    = energy_q;
    assign improved  = improved_q;

    genvar gc;
    generate
        for (gc = 0; gc < COLS_PER_BEAT; gc++) begin : g_col
            ising_col_dot #(
                .N(VECTOR_SIZE), .W(J_ELEMENT_WIDTH),
                .J_SIGNED(J_SIGNED), .DOT_WIDTH(DOT_WIDTH)
            ) u_dot (
                .sigma(sigma_q),
                .col  (j_chunk[gc*COL_BITS +: COL_BITS]),
                .dot  (dot_c[gc])
            );
        end
    endgenerate

    function automatic logic [ENERGY_WIDTH-1:0] sext_dot(input logic [DOT_WIDTH-1:0] d);
        return {{(ENERGY_WIDTH-DOT_WIDTH){d[DOT_WIDTH-1]}}, d};
    endfunction

    // Beat contribution: each column dot weighted by that column's own spin.
    always_comb begin
        contrib_c = '0;
        for (int c = 0; c < COLS_PER_BEAT; c++) begin
            if (sgn_q[c]) contrib_c = contrib_c + sext_dot(dot_q[c]);
            else          contrib_c = contrib_c - sext_dot(dot_q[c]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; DRAIN ends once nothing is left in the two pipeline stages.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (accept && last_beat) state_d = DRAIN;
            DRAIN:   if (abort) state_d = IDLE;
                     else if (vld_pipe == 2'b00) state_d = RESULT;
            RESULT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, dot/contribution pipeline, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sigma_q    <= '0;
            eprev_q    <= '0;
            beat_q     <= '0;
            dot_q      <= '0;
            sgn_q      <= '0;
            contrib_q  <= '0;
            acc_q      <= '0;
            vld_pipe   <= '0;
            energy_q   <= '0;
            improved_q <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            if (start_hit) begin
                sigma_q <= sigma;
                eprev_q <= energy_previous;
                acc_q   <= '0;
                beat_q  <= '0;
            end
            if (accept) begin
                dot_q  <= dot_c;
                sgn_q  <= sigma_q[beat_q*COLS_PER_BEAT +: COLS_PER_BEAT];
                beat_q <= beat_q + BEAT_W'(1);
            end
            if (vld_pipe[0]) contrib_q <= contrib_c;
            if (vld_pipe[1]) acc_q <= acc_q + contrib_q;
            if (state_q == DRAIN && state_d == RESULT) begin
                energy_q   <= acc_q;
                improved_q <= $signed(acc_q) < $signed(eprev_q);
            end
            // Aborted work in flight must never reach the accumulator.
            if (abort_hit) vld_pipe <= '0;
        end
    end
endmodule

// File: tb/tb_ising_energy_engine.sv
// Bench for ising_energy_engine: an unsigned and a signed instance share all
// stimulus; results are compared with a direct sigma^T J sigma reference.
module tb_ising_energy_engine;
    localparam int N  = 256;
    localparam int W  = 4;
    localparam int C  = 4;
    localparam int NB = N / C;
    localparam int EW = W + 2*$clog2(N) + 1;

    logic clk = 0;
    logic rst, start, abort, j_valid, out_ready;
    logic [N-1:0]     sigma;
    logic [EW-1:0]    energy_previous;
    logic [N*C*W-1:0] j_chunk;
    logic j_ready_u, busy_u, out_valid_u, improved_u;
    logic j_ready_s, busy_s, out_valid_s, improved_s;
    logic [EW-1:0] energy_u, energy_s;

    int checks = 0;
    int errors = 0;

    bit [W-1:0] jm [N][N];
    logic [N-1:0] sg;

    always #5 clk = ~clk;

    ising_energy_engine #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(W), .J_SIGNED(0), .COLS_PER_BEAT(C)) dut_u (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sigma(sigma),
        .energy_previous(energy_previous), .j_valid(j_valid), .j_ready(j_ready_u),
        .j_chunk(j_chunk), .busy(busy_u), .out_valid(out_valid_u), .out_ready(out_ready),
        .energy(energy_u), .improved(improved_u));

    ising_energy_engine #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(W), .J_SIGNED(1), .COLS_PER_BEAT(C)) dut_s (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sigma(sigma),
        .energy_previous(energy_previous), .j_valid(j_valid), .j_ready(j_ready_s),
        .j_chunk(j_chunk), .busy(busy_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .energy(energy_s), .improved(improved_s));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Energy straight from the definition: sum over r,c of s_r * J[r][c] * s_c.
    function automatic longint model(input bit signed_j);
        longint e = 0;
        int v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                v = int'(jm[r][c]);
                if (signed_j && v >= (1 << (W-1))) v -= (1 << W);
                e += (sg[r] == sg[c]) ? v : -v;
            end
        return e;
    endfunction

    task automatic fill_const(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) jm[r][c] = W'(v);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) jm[r][c] = W'($urandom_range((1 << W) - 1));
        for (int r = 0; r < N; r++) sg[r] = 1'($urandom_range(1));
    endtask

    task automatic drive(input int b);
        for (int c = 0; c < C; c++)
            for (int r = 0; r < N; r++) j_chunk[(c*N+r)*W +: W] = jm[r][b*C+c];
    endtask

    task automatic run_eval(input string tag, input longint eprev, input int stall_pct,
                            input int hold, input bit chk_edge);
        longint exp_u, exp_s;
        int b, cyc, last_cyc;
        bit hs, stable;
        logic [EW-1:0] e_u, e_s;
        logic i_u, i_s;
        exp_u = model(0);
        exp_s = model(1);
        @(negedge clk);
        sigma = sg; energy_previous = EW'(eprev); start = 1; j_valid = 0;
        @(posedge clk); #1;
        start = 0; b = 0; cyc = 0; last_cyc = 0;
        while (!out_valid_u && cyc < 1000) begin
            @(negedge clk);
            if (b < NB) begin
                j_valid = ($urandom_range(99) >= stall_pct);
                drive(b);
            end else j_valid = 1'($urandom_range(1));
            // Stray starts with scrambled operands while busy must be ignored.
            if ($urandom_range(7) == 0) begin
                start = 1; sigma = ~sigma; energy_previous = ~energy_previous;
            end else start = 0;
            hs = j_valid && j_ready_u;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                b++;
                if (b == NB) last_cyc = cyc;
            end
        end
        start = 0; j_valid = 0;
        if (!out_valid_u) begin
            chk({tag, " timeout"}, 0, 1);
            return;
        end
        chk({tag, " latency"}, cyc - last_cyc, 3);
        if (chk_edge) chk({tag, " ov_edge"}, cyc, NB + 3);
        chk({tag, " ov_s"}, out_valid_s, 1);
        chk({tag, " energy_u"}, longint'($signed(energy_u)), exp_u);
        chk({tag, " improved_u"}, improved_u, (exp_u < eprev) ? 1 : 0);
        chk({tag, " energy_s"}, longint'($signed(energy_s)), exp_s);
        chk({tag, " improved_s"}, improved_s, (exp_s < eprev) ? 1 : 0);
        e_u = energy_u; e_s = energy_s; i_u = improved_u; i_s = improved_s;
        stable = 1;
        repeat (hold) begin
            @(negedge clk); out_ready = 0;
            @(posedge clk); #1;
            if (!out_valid_u || energy_u !== e_u || improved_u !== i_u ||
                !out_valid_s || energy_s !== e_s || improved_s !== i_s) stable = 0;
        end
        chk({tag, " stable"}, stable, 1);
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, " ov_drop"}, out_valid_u, 0);
        chk({tag, " idle"}, busy_u, 0);
        chk({tag, " energy_hold"}, longint'($signed(energy_u)), exp_u);
    endtask

    // Feed nb beats, then abort (or reset) in the following cycle.
    task automatic partial(input string tag, input int nb, input bit use_rst);
        int b, cyc;
        bit hs, quiet;
        @(negedge clk);
        sigma = sg; start = 1; j_valid = 0;
        @(posedge clk); #1;
        start = 0; b = 0; cyc = 0;
        while (b < nb && cyc < 1000) begin
            @(negedge clk);
            j_valid = 1; drive(b);
            hs = j_valid && j_ready_u;
            @(posedge clk); #1;
            cyc++;
            if (hs) b++;
        end
        chk({tag, " beats"}, b, nb);
        @(negedge clk);
        if (use_rst) rst = 1; else abort = 1;
        j_valid = 1; drive(b);
        @(posedge clk); #1;
        rst = 0; abort = 0; j_valid = 0;
        chk({tag, " busy"}, busy_u, 0);
        chk({tag, " busy_s"}, busy_s, 0);
        chk({tag, " j_ready"}, j_ready_u, 0);
        chk({tag, " out_valid"}, out_valid_u, 0);
        if (use_rst) begin
            chk({tag, " j_ready_s"}, j_ready_s, 0);
            chk({tag, " energy_u"}, longint'(energy_u), 0);
            chk({tag, " energy_s"}, longint'(energy_s), 0);
            chk({tag, " improved_u"}, improved_u, 0);
        end else begin
            quiet = 1;
            repeat (10) begin
                @(posedge clk); #1;
                if (out_valid_u || busy_u || out_valid_s) quiet = 0;
            end
            chk({tag, " quiet"}, quiet, 1);
        end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; j_valid = 0; out_ready = 0;
        sigma = '0; energy_previous = '0; j_chunk = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy_u, 0);
        chk("reset j_ready", j_ready_u, 0);
        chk("reset out_valid", out_valid_u, 0);
        chk("reset energy", longint'(energy_u), 0);
        chk("reset improved", improved_u, 0);
        @(negedge clk); rst = 0;

        fill_const(1); sg = '1;
        run_eval("ones_pos", 65536, 0, 2, 1);
        fill_const(1); sg = '0;
        run_eval("ones_neg", 65536, 0, 2, 1);
        fill_const(15);
        for (int i = 0; i < N; i++) sg[i] = (i % 2 == 0);
        run_eval("alt15", 0, 0, 2, 1);
        fill_const(15); sg = '1;
        run_eval("max15", 983041, 0, 2, 1);
        fill_const(8); sg = '1;
        run_eval("msb8", 0, 0, 2, 1);

        for (int s = 0; s < 100; s++) begin
            longint ep;
            fill_rand();
            ep = model(0) + longint'($urandom_range(2)) - 1;
            run_eval($sformatf("rand%0d", s), ep, 50, 5, 0);
        end

        fill_const(1); sg = '1;
        partial("abort", 20, 0);
        run_eval("after_abort", 65537, 0, 1, 1);
        partial("rst", 30, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
